// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: issues one imem read at a time, buffers {pc, instr, fault} toward decode, drives pc_next.
// Optional macro IFU_PERF_CNT_EN adds perf_fetched / perf_stall counters.
module instr_fetch_unit #(
    parameter int          FIFO_DEPTH = 2,
    parameter int unsigned PC_STEP    = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [63:0] pc_curr,
    output logic [63:0] pc_next,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [63:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        imem_rsp_err,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_instr,
    output logic [63:0] if_pc,
    output logic        if_fault,
    output logic [1:0]  dbg_state,
    output logic        dbg_rsp_unexpected
`ifdef IFU_PERF_CNT_EN
    ,
    output logic [63:0] perf_fetched,
    output logic [63:0] perf_stall
`endif
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_DRAIN = 2'd2,
        S_HALT  = 2'd3
    } state_t;

    state_t        state, state_nxt;
    logic [63:0]   req_pc;
    logic [63:0]   fifo_pc    [FIFO_DEPTH];
    logic [31:0]   fifo_instr [FIFO_DEPTH];
    logic          fifo_fault [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;

    logic        has_space, aligned, req_fire, rsp_keep, mis_push, push, pop;
    logic [63:0] push_pc;
    logic [31:0] push_instr;
    logic        push_fault;

    // Handshakes: a transfer happens on a cycle where valid & ready are both high at the rising edge;
    // valid never depends combinationally on the same channel's ready, and the response channel has no ready.
    assign has_space = count < CW'(FIFO_DEPTH);
    assign aligned   = (pc_curr[1:0] == 2'b00);
    assign req_fire  = imem_req_valid & imem_req_ready;
    assign rsp_keep  = (state == S_WAIT) & imem_rsp_valid & ~redirect_valid;
    assign mis_push  = (state == S_IDLE) & ~redirect_valid & ~aligned & has_space;
    assign push      = rsp_keep | mis_push;
    assign pop       = if_valid & if_ready;

    assign push_pc    = rsp_keep ? req_pc : pc_curr;
    assign push_instr = rsp_keep ? imem_rsp_data : 32'h0;
    assign push_fault = rsp_keep ? imem_rsp_err : 1'b1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= S_IDLE;
            req_pc <= '0;
        end else begin
            state <= state_nxt;
            if (req_fire) req_pc <= pc_curr;
        end
    end

    // A redirect always wins; a response that coincides with it is dropped.
    always_comb begin
        state_nxt = state;
        if (redirect_valid) begin
            case (state)
                S_WAIT, S_DRAIN: state_nxt = imem_rsp_valid ? S_IDLE : S_DRAIN;
                default:         state_nxt = S_IDLE;
            endcase
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_fire)      state_nxt = S_WAIT;
                    else if (mis_push) state_nxt = S_HALT;
                end
                S_WAIT:  if (imem_rsp_valid) state_nxt = imem_rsp_err ? S_HALT : S_IDLE;
                S_DRAIN: if (imem_rsp_valid) state_nxt = S_IDLE;
                default: state_nxt = state;
            endcase
        end
    end

    always_comb begin
        imem_req_valid     = ~reset & (state == S_IDLE) & ~redirect_valid & aligned & has_space;
        imem_req_addr      = pc_curr;
        dbg_state          = state;
        dbg_rsp_unexpected = imem_rsp_valid & ((state == S_IDLE) | (state == S_HALT));
        if (reset)               pc_next = pc_curr;
        else if (redirect_valid) pc_next = redirect_pc;
        else if (req_fire)       pc_next = pc_curr + 64'(PC_STEP);
        else                     pc_next = pc_curr;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (redirect_valid) begin
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_pc[wr_ptr]    <= push_pc;
            fifo_instr[wr_ptr] <= push_instr;
            fifo_fault[wr_ptr] <= push_fault;
        end
    end

    // Head fields are forced to zero while empty so decode never sees stale storage.
    assign if_valid = (count != '0);
    assign if_instr = if_valid ? fifo_instr[rd_ptr] : 32'h0;
    assign if_pc    = if_valid ? fifo_pc[rd_ptr]    : 64'h0;
    assign if_fault = if_valid ? fifo_fault[rd_ptr] : 1'b0;

`ifdef IFU_PERF_CNT_EN
    logic stall_cycle;
    assign stall_cycle = (state == S_IDLE) & ~redirect_valid &
                         (~has_space | (aligned & ~imem_req_ready));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_fetched <= '0;
            perf_stall   <= '0;
        end else begin
            if (push & ~push_fault) perf_fetched <= perf_fetched + 64'd1;
            if (stall_cycle)        perf_stall   <= perf_stall + 64'd1;
        end
    end
`endif
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: PC register + memory model around the DUT, table vectors and scoreboarded sequences.
module tb_instr_fetch_unit;
  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [63:0] pc_curr = '0, pc_next;
  logic        redirect_valid = 1'b0;
  logic [63:0] redirect_pc = '0;
  logic        imem_req_valid, imem_req_ready = 1'b0;
  logic [63:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        imem_rsp_err = 1'b0;
  logic        if_valid, if_ready = 1'b0;
  logic [31:0] if_instr;
  logic [63:0] if_pc;
  logic        if_fault;
  logic [1:0]  dbg_state;
  logic        dbg_rsp_unexpected;
`ifdef IFU_PERF_CNT_EN
  logic [63:0] perf_fetched, perf_stall;
`endif

  always #5 clk = ~clk;

  instr_fetch_unit #(.FIFO_DEPTH(DEPTH), .PC_STEP(4)) dut (
    .clk(clk), .reset(reset), .pc_curr(pc_curr), .pc_next(pc_next),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data), .imem_rsp_err(imem_rsp_err),
    .if_valid(if_valid), .if_ready(if_ready), .if_instr(if_instr), .if_pc(if_pc), .if_fault(if_fault),
    .dbg_state(dbg_state), .dbg_rsp_unexpected(dbg_rsp_unexpected)
`ifdef IFU_PERF_CNT_EN
    , .perf_fetched(perf_fetched), .perf_stall(perf_stall)
`endif
  );

  int n_checks = 0;
  int n_pass = 0;
  logic [96:0] exp_q[$];
  logic [63:0] issue_log[$];
  logic [63:0] pop_log[$];
  int n_poison_seen = 0;

  // environment knobs
  bit follow = 0, ready_knob = 0, dec_knob = 0, inject = 0, poison = 0, err_en = 0, pc_force_en = 0;
  logic [63:0] err_addr = '0, pc_force = '0, pc_cap = '0;
  int mem_lat = 1;
  bit mem_pend = 0, mem_kill = 0;
  logic [63:0] mem_addr = '0;
  int mem_cnt = 0;

  // samples taken 1 time unit after the falling edge
  logic s_req_valid, s_if_valid, s_if_fault, s_rsp_unexp;
  logic [63:0] s_req_addr, s_pc_next, s_if_pc;
  logic [31:0] s_if_instr;
  logic [1:0] s_state;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
  endtask

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return 32'h13 + {a[23:0], 8'h00};
  endfunction

  function automatic logic [63:0] get_pop(input int i);
    return (pop_log.size() > i) ? pop_log[i] : 64'hBAD0_BAD0_BAD0_BAD0;
  endfunction

  function automatic logic [63:0] get_issue(input int i);
    return (issue_log.size() > i) ? issue_log[i] : 64'hBAD0_BAD0_BAD0_BAD0;
  endfunction

  // One clock cycle: drive at negedge, sample and update models, then wait for posedge.
  task automatic step(input bit rv, input logic [63:0] rpc);
    bit rsp_now;
    logic [31:0] rdata;
    logic rerr;
    logic [96:0] e;
    @(negedge clk);
    if (pc_force_en) pc_curr = pc_force;
    else if (follow) pc_curr = pc_cap;
    redirect_valid = rv;
    redirect_pc = rpc;
    imem_req_ready = ready_knob;
    if_ready = dec_knob;
    rsp_now = mem_pend && (mem_cnt == 0);
    rdata = poison ? 32'hDEADBEEF : mem_word(mem_addr);
    rerr = err_en && (mem_addr == err_addr);
    if (inject) begin
      imem_rsp_valid = 1'b1; imem_rsp_data = 32'hDEADBEEF; imem_rsp_err = 1'b0;
    end else begin
      imem_rsp_valid = rsp_now;
      imem_rsp_data = rsp_now ? rdata : 32'h0;
      imem_rsp_err = rsp_now ? rerr : 1'b0;
    end
    #1;
    s_req_valid = imem_req_valid; s_req_addr = imem_req_addr; s_pc_next = pc_next;
    s_if_valid = if_valid; s_if_pc = if_pc; s_if_instr = if_instr; s_if_fault = if_fault;
    s_rsp_unexp = dbg_rsp_unexpected; s_state = dbg_state;
    if (exp_q.size() >= DEPTH) check("req_while_full", 64'(imem_req_valid), 64'h0);
    if (if_valid && if_ready) begin
      pop_log.push_back(if_pc);
      if (if_instr == 32'hDEADBEEF) n_poison_seen++;
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL sb_unexpected: popped pc 0x%0h instr 0x%0h, required no entry", if_pc, if_instr);
      end else begin
        e = exp_q.pop_front();
        check("sb_pc", if_pc, e[96:33]);
        check("sb_instr", 64'(if_instr), 64'(e[32:1]));
        check("sb_fault", 64'(if_fault), 64'(e[0]));
      end
    end
    if (rv) exp_q.delete();
    if (rsp_now && !inject) begin
      mem_pend = 0;
      if (!rv && !mem_kill) exp_q.push_back({mem_addr, rdata, rerr});
    end else if (mem_pend) begin
      mem_cnt--;
      if (rv) mem_kill = 1;
    end
    if (imem_req_valid && imem_req_ready) begin
      issue_log.push_back(imem_req_addr);
      mem_pend = 1; mem_addr = imem_req_addr; mem_cnt = mem_lat - 1; mem_kill = 0;
    end
    pc_cap = pc_next;
    @(posedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    pc_curr = '0; pc_cap = '0; redirect_valid = 0; imem_req_ready = 0; if_ready = 0;
    imem_rsp_valid = 0; imem_rsp_data = '0; imem_rsp_err = 0;
    exp_q.delete(); issue_log.delete(); pop_log.delete();
    mem_pend = 0; mem_kill = 0; inject = 0; poison = 0; err_en = 0; pc_force_en = 0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  typedef struct {
    logic [63:0] pc;
    bit          rv;
    logic [63:0] rpc;
    bit          rdy;
    bit          exp_valid;
    logic [63:0] exp_next;
  } vec_t;

  vec_t vt[7];

  initial begin
    vt[0] = '{64'h0,                  1'b0, 64'h0,    1'b1, 1'b1, 64'h4};
    vt[1] = '{64'h100,                1'b0, 64'h0,    1'b0, 1'b1, 64'h100};
    vt[2] = '{64'hFFFF_FFFF_FFFF_FFFC, 1'b0, 64'h0,    1'b1, 1'b1, 64'h0};
    vt[3] = '{64'h6,                  1'b0, 64'h0,    1'b1, 1'b0, 64'h6};
    vt[4] = '{64'h40,                 1'b1, 64'h2000, 1'b1, 1'b0, 64'h2000};
    vt[5] = '{64'h41,                 1'b1, 64'h80,   1'b1, 1'b0, 64'h80};
    vt[6] = '{64'h3,                  1'b0, 64'h0,    1'b0, 1'b0, 64'h3};

    // reset state
    reset = 1'b1;
    #2;
    check("rst_req_valid", 64'(imem_req_valid), 64'h0);
    check("rst_if_valid", 64'(if_valid), 64'h0);
    check("rst_if_instr", 64'(if_instr), 64'h0);
    check("rst_if_pc", if_pc, 64'h0);
    check("rst_state", 64'(dbg_state), 64'h0);
    do_reset();

    // table: single-cycle issue / pc_next decisions from an empty, idle unit
    for (int i = 0; i < 7; i++) begin
      do_reset();
      follow = 0; ready_knob = vt[i].rdy; dec_knob = 0;
      pc_force_en = 1; pc_force = vt[i].pc;
      step(vt[i].rv, vt[i].rpc);
      pc_force_en = 0;
      check($sformatf("vec%0d_req_valid", i), 64'(s_req_valid), 64'(vt[i].exp_valid));
      check($sformatf("vec%0d_pc_next", i), s_pc_next, vt[i].exp_next);
      if (vt[i].exp_valid) check($sformatf("vec%0d_req_addr", i), s_req_addr, vt[i].pc);
    end

    // sequential fetch from 0 with a 1-cycle memory
    do_reset();
    follow = 1; ready_knob = 1; dec_knob = 1; mem_lat = 1;
    step(0, '0);
    check("t1_req_valid", 64'(s_req_valid), 64'h1);
    check("t1_req_addr", s_req_addr, 64'h0);
    check("t1_pc_next", s_pc_next, 64'h4);
    step(0, '0);
    check("t1_if_valid_early", 64'(s_if_valid), 64'h0);
    step(0, '0);
    check("t1_if_valid", 64'(s_if_valid), 64'h1);
    check("t1_if_pc", s_if_pc, 64'h0);
    check("t1_if_instr", 64'(s_if_instr), 64'h13);
    check("t1_if_fault", 64'(s_if_fault), 64'h0);
    for (int k = 0; k < 30 && pop_log.size() < 3; k++) step(0, '0);
    check("t1_pop0", get_pop(0), 64'h0);
    check("t1_pop1", get_pop(1), 64'h4);
    check("t1_pop2", get_pop(2), 64'h8);

    // decode stalled: FIFO fills to DEPTH and fetch stops
    do_reset();
    follow = 1; ready_knob = 1; dec_knob = 0; mem_lat = 1;
    repeat (10) step(0, '0);
    check("t2_issues", 64'(issue_log.size()), 64'(DEPTH));
    check("t2_req_valid", 64'(s_req_valid), 64'h0);
    check("t2_pc_hold", s_pc_next, 64'h8);
    check("t2_if_valid", 64'(s_if_valid), 64'h1);
    check("t2_buffered", 64'(exp_q.size()), 64'(DEPTH));
    dec_knob = 1;
    step(0, '0);
    check("t2_no_pop_bypass", 64'(s_req_valid), 64'h0);
    for (int k = 0; k < 10 && pop_log.size() < 2; k++) step(0, '0);
    check("t2_pop0", get_pop(0), 64'h0);
    check("t2_pop1", get_pop(1), 64'h4);

    // redirect while WAIT: the late response must be dropped
    do_reset();
    follow = 1; ready_knob = 1; dec_knob = 1; mem_lat = 3; poison = 1; n_poison_seen = 0;
    step(0, '0);
    step(1, 64'h1000);
    check("t3_pc_next", s_pc_next, 64'h1000);
    step(0, '0);
    check("t3_drain_req_a", 64'(s_req_valid), 64'h0);
    step(0, '0);
    check("t3_drain_req_b", 64'(s_req_valid), 64'h0);
    poison = 0;
    step(0, '0);
    check("t3_fifo_empty", 64'(s_if_valid), 64'h0);
    for (int k = 0; k < 20 && pop_log.size() < 1; k++) step(0, '0);
    check("t3_issue_addr", get_issue(1), 64'h1000);
    check("t3_pop0", get_pop(0), 64'h1000);
    check("t3_no_poison", 64'(n_poison_seen), 64'h0);
    mem_lat = 1;

    // misaligned pc: fault entry, halt until redirect
    do_reset();
    follow = 1; ready_knob = 1; dec_knob = 0; mem_lat = 1;
    step(1, 64'h6);
    step(0, '0);
    check("t4_req_valid", 64'(s_req_valid), 64'h0);
    check("t4_pc_hold", s_pc_next, 64'h6);
    exp_q.push_back({64'h6, 32'h0, 1'b1});
    step(0, '0);
    check("t4_if_valid", 64'(s_if_valid), 64'h1);
    check("t4_if_pc", s_if_pc, 64'h6);
    check("t4_if_fault", 64'(s_if_fault), 64'h1);
    check("t4_if_instr", 64'(s_if_instr), 64'h0);
    check("t4_halt", 64'(s_state), 64'h3);
    repeat (3) step(0, '0);
    dec_knob = 1;
    repeat (4) step(0, '0);
    check("t4_no_issue", 64'(issue_log.size()), 64'h0);
    check("t4_popped", get_pop(0), 64'h6);
    step(1, 64'h8);
    for (int k = 0; k < 10 && issue_log.size() < 1; k++) step(0, '0);
    check("t4_resume", get_issue(0), 64'h8);

    // bus error at 0x20, then redirect colliding with a response
    do_reset();
    follow = 1; ready_knob = 1; dec_knob = 1; mem_lat = 1; err_en = 1; err_addr = 64'h20;
    step(1, 64'h20);
    step(0, '0);
    step(0, '0);
    repeat (4) step(0, '0);
    check("t5_halt_issues", 64'(issue_log.size()), 64'h1);
    check("t5_fault_pop", get_pop(0), 64'h20);
    err_en = 0; mem_lat = 2;
    step(1, 64'h40);
    step(0, '0);
    step(0, '0);
    step(1, 64'h80);
    check("t5_redirect_pc", s_pc_next, 64'h80);
    for (int k = 0; k < 20 && pop_log.size() < 2; k++) step(0, '0);
    check("t5_issue_40", get_issue(1), 64'h40);
    check("t5_issue_80", get_issue(2), 64'h80);
    check("t5_pop_80", get_pop(1), 64'h80);
    mem_lat = 1;

    // asynchronous reset in WAIT, stale response afterwards
    do_reset();
    follow = 1; ready_knob = 1; dec_knob = 0; mem_lat = 1; n_poison_seen = 0;
    step(0, '0);
    step(0, '0);
    step(0, '0);
    #3 reset = 1'b1;
    #1;
    check("t6_req_valid", 64'(imem_req_valid), 64'h0);
    check("t6_if_valid", 64'(if_valid), 64'h0);
    check("t6_if_instr", 64'(if_instr), 64'h0);
    check("t6_if_pc", if_pc, 64'h0);
    check("t6_if_fault", 64'(if_fault), 64'h0);
    check("t6_pc_next", pc_next, pc_curr);
`ifdef IFU_PERF_CNT_EN
    check("t6_perf_fetched", perf_fetched, 64'h0);
    check("t6_perf_stall", perf_stall, 64'h0);
`endif
    exp_q.delete(); issue_log.delete(); pop_log.delete(); mem_pend = 0;
    @(negedge clk);
    pc_curr = pc_cap; imem_req_ready = 0;
    @(negedge clk);
    reset = 1'b0;
    ready_knob = 0; inject = 1;
    step(0, '0);
    check("t6_stale_flag", 64'(s_rsp_unexp), 64'h1);
    inject = 0;
    step(0, '0);
    check("t6_stale_dropped", 64'(s_if_valid), 64'h0);
    ready_knob = 1; dec_knob = 1;
    for (int k = 0; k < 20 && pop_log.size() < 1; k++) step(0, '0);
    check("t6_restart_addr", get_issue(0), 64'h8);
    check("t6_restart_pop", get_pop(0), 64'h8);
    check("t6_no_poison", 64'(n_poison_seen), 64'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
